// File: rtl/clk_mux_switch_ctrl.sv
// clk_mux_switch_ctrl: sequences a glitch-free clock-mux switch.
// The downstream clock gate is closed, the mux select is changed, the
// controller waits until the mux reports the new input, and the gate stays
// closed for a settling interval. A one-cycle ack marks completion.
// Optional feature macro: CLK_SWITCH_TIMEOUT_EN bounds the wait for the
// mux confirmation. On expiry the select reverts and a sticky error is raised.
module clk_mux_switch_ctrl #(
  parameter int DRAIN_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic target_i,
  input  logic clk_selected_i,
  output logic select_o,
  output logic clk_gate_en_o,
  output logic busy_o,
  output logic ack_o,
  output logic err_o
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int MAX_CYC = max3(DRAIN_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Counter loads are one less than the interval because the count reaching
  // zero is itself the last cycle of the interval.
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef CLK_SWITCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [1:0]       sync_q;
  logic             sel_sync;
  logic             tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             select_q;
  logic             gate_q;
  logic             busy_q;
  logic             ack_q;
  logic             cnt_zero;

  assign sel_sync = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  // Two-flop synchronizer for the mux-reported selection (foreign domain).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], clk_selected_i};
    end
  end

`ifdef CLK_SWITCH_TIMEOUT_EN
  logic err_q;
`endif

  // Switch sequencer; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      tgt_q    <= 1'b0;
      cnt_q    <= '0;
      select_q <= 1'b0;
      gate_q   <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
`ifdef CLK_SWITCH_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            busy_q <= 1'b1;
            if (target_i == select_q) begin
              // Already on the requested input: complete without gating.
              state_q <= DONE;
              ack_q   <= 1'b1;
            end else begin
              state_q <= DRAIN;
              tgt_q   <= target_i;
              gate_q  <= 1'b0;
              cnt_q   <= DRAIN_LOAD;
`ifdef CLK_SWITCH_TIMEOUT_EN
              err_q   <= 1'b0;
`endif
            end
          end
        end
        DRAIN: begin
          if (cnt_zero) begin
            state_q  <= WAIT;
            select_q <= tgt_q;
`ifdef CLK_SWITCH_TIMEOUT_EN
            cnt_q    <= TIMEOUT_LOAD;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WAIT: begin
          // A confirmation in the final timeout cycle still counts as success.
          if (sel_sync == tgt_q) begin
            state_q <= SETTLE;
            cnt_q   <= SETTLE_LOAD;
`ifdef CLK_SWITCH_TIMEOUT_EN
          end else if (cnt_zero) begin
            // Only two inputs exist, so the pre-switch select is ~tgt_q.
            state_q  <= SETTLE;
            cnt_q    <= SETTLE_LOAD;
            select_q <= ~tgt_q;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
`endif
          end
        end
        SETTLE: begin
          if (cnt_zero) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
            gate_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gate_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign select_o      = select_q;
  assign clk_gate_en_o = gate_q;
  assign busy_o        = busy_q;
  assign ack_o         = ack_q;
`ifdef CLK_SWITCH_TIMEOUT_EN
  assign err_o         = err_q;
`else
  assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_clk_mux_switch_ctrl.sv
// Bench for clk_mux_switch_ctrl. Each switch is predicted from its timeline:
// the cycle the wait is satisfied is derived from when the mux-reported
// select changes plus the synchronizer latency. All per-cycle expectations
// follow from the interval lengths.
module tb_clk_mux_switch_ctrl;

  localparam int D = 4;
  localparam int S = 8;
  localparam int T = 256;

  logic clk = 1'b0;
  logic rst, req, tgt, csel;
  logic sel, gate, busy, ack, err;

  int checks = 0;
  int errors = 0;

  // Model state between transactions.
  logic m_sel = 1'b0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  clk_mux_switch_ctrl #(
    .DRAIN_CYCLES  (D),
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .target_i      (tgt),
    .clk_selected_i(csel),
    .select_o      (sel),
    .clk_gate_en_o (gate),
    .busy_o        (busy),
    .ack_o         (ack),
    .err_o         (err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_sel, input logic e_gate,
                         input logic e_busy, input logic e_ack, input logic e_err);
    chk({tag, ".select"}, sel, e_sel);
    chk({tag, ".gate"}, gate, e_gate);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".ack"}, ack, e_ack);
    chk({tag, ".err"}, err, e_err);
  endtask

  // One request. Entered at a negedge while idle. Cycle 0 is the cycle after
  // the edge that samples the request. The mux is made to report the new
  // input from the negedge of cycle m (m = -1: together with the request).
  // p >= 0 injects a one-cycle opposite request during DRAIN.
  // hold keeps req high past the ack so it is re-evaluated in IDLE.
  task automatic do_switch(input string tag, input logic t, input int m,
                           input int p, input bit hold);
    bit   sw;
    bit   revert;
    int   c;
    int   done_k;
    int   last;
    logic old;
    logic e_sel, e_gate, e_busy, e_ack, e_err;
    sw     = (t != m_sel);
    old    = m_sel;
    revert = 1'b0;
    c      = 0;
    if (sw) begin
      c = (m + 2 > D) ? m + 2 : D;
`ifdef CLK_SWITCH_TIMEOUT_EN
      if (c > D + T - 1) begin
        c      = D + T - 1;
        revert = 1'b1;
      end
`endif
      done_k = c + S + 1;
    end else begin
      done_k = 0;
    end
    last = hold ? done_k + 3 : done_k + 1;
    req = 1'b1;
    tgt = t;
    if (sw && m == -1) csel = t;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      e_ack  = (j == done_k) || (hold && j == done_k + 2);
      e_busy = (j <= done_k) || (hold && j == done_k + 2);
      if (sw) begin
        if (j < D)      e_sel = old;
        else if (j <= c) e_sel = t;
        else            e_sel = revert ? old : t;
        e_gate = (j > c + S);
        e_err  = revert && (j > c);
      end else begin
        e_sel  = m_sel;
        e_gate = 1'b1;
        e_err  = m_err;
      end
      chk_all($sformatf("%s[%0d]", tag, j), e_sel, e_gate, e_busy, e_ack, e_err);
      if (sw && j == m) csel = t;
      if (!hold && j == 0) req = 1'b0;
      if (hold && j == done_k + 2) req = 1'b0;
      if (j == p) begin
        req = 1'b1;
        tgt = ~t;
      end
      if (j == p + 1) begin
        req = 1'b0;
        tgt = t;
      end
    end
    if (sw) begin
      m_sel = revert ? old : t;
      m_err = revert;
    end
  endtask

  // Starts a switch whose confirmation never arrives, lets it sit in WAIT
  // for n cycles, then resets and checks the abort leaves no ack behind.
  task automatic reset_in_wait(input string tag, input int n);
    req = 1'b1;
    tgt = ~m_sel;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 0) req = 1'b0;
      if (j == n - 1 || (j % 1000) == 999) begin
        chk({tag, ".busy_wait"}, busy, 1'b1);
        chk({tag, ".gate_wait"}, gate, 1'b0);
        chk({tag, ".err_wait"}, err, 1'b0);
      end
    end
    rst  = 1'b1;
    csel = 1'b0;
    @(negedge clk);
    chk_all({tag, ".after_rst"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk_all($sformatf("%s.post_rst[%0d]", tag, j), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    m_sel = 1'b0;
    m_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic t;
    int   m;
    int   p;
    bit   hold;
    rst  = 1'b1;
    req  = 1'b0;
    tgt  = 1'b0;
    csel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_all("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic switch to clk1, mux confirms three cycles after the select moves.
    do_switch("sw_to_1", 1'b1, D + 3, -10, 1'b0);
    // Request for the input already selected: no gating, immediate ack.
    do_switch("same_1", 1'b1, 0, -10, 1'b0);
    // Second request during DRAIN must be ignored.
    do_switch("pulse_drain", 1'b0, D + 1, 1, 1'b0);
    // Early mux report: WAIT satisfied on entry.
    do_switch("early_conf", 1'b1, -1, -10, 1'b0);
    // req held high across the ack is taken again in IDLE.
    do_switch("hold_req", 1'b0, D + 2, -10, 1'b1);

`ifdef CLK_SWITCH_TIMEOUT_EN
    // Mux never confirms: timeout reverts the select and raises err.
    do_switch("timeout", ~m_sel, 1_000_000, -10, 1'b0);
    // A same-target request leaves the sticky error in place.
    do_switch("err_sticky", m_sel, 0, -10, 1'b0);
    // The next accepted switch clears it.
    do_switch("err_clear", ~m_sel, D, -10, 1'b0);
    reset_in_wait("rst_wait", D + 5);
`else
    // Without the timeout the controller waits indefinitely.
    reset_in_wait("stuck_wait", 10000);
`endif

    for (int i = 0; i < 25; i++) begin
      t    = 1'($urandom_range(0, 1));
      m    = int'($urandom_range(0, D + 7)) - 1;
      hold = ($urandom_range(0, 3) == 0);
      p    = -10;
      if (t != m_sel && !hold && $urandom_range(0, 1) == 1)
        p = int'($urandom_range(0, D - 2));
      do_switch($sformatf("rnd%0d", i), t, m, p, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
